clkdiv_cfg_sequencer: RTL and testbench

AXI4-Lite master that programs and verifies the four 32-bit registers of one clock-divider slave from a single start request. Sits between the DAQ control logic and the divider's S00_AXI port and replaces software register pokes. It writes all four registers in a fixed order, reads each back, compares, and reports done or error.

---
 rtl/clkdiv_cfg_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_clkdiv_cfg_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_cfg_sequencer.sv
// AXI4-Lite master that writes the four clock-divider registers from a shadow copy,
// reads each one back, and reports done or a coded error.
module clkdiv_cfg_sequencer #(
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_TIMEOUT    = 255
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    input  logic [31:0]             cfg_ctrl,
    input  logic [31:0]             cfg_div,
    input  logic [31:0]             cfg_high,
    input  logic [31:0]             cfg_phase,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              err_code,
    output logic [1:0]              err_index,
    output logic [2:0]              fsm_state,
    output logic [C_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [31:0]             m_axi_wdata,
    output logic [3:0]              m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [31:0]             m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    // Handshakes: a transfer happens on a rising ACLK edge where valid and ready are both high;
    // once raised, a valid stays high with stable payload until its transfer, except on timeout abort.

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_AW_W = 3'd1,
        S_WR_B    = 3'd2,
        S_RD_AR   = 3'd3,
        S_RD_R    = 3'd4,
        S_DONE    = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    localparam logic [1:0] ERR_RESP     = 2'b01;
    localparam logic [1:0] ERR_MISMATCH = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;
    localparam logic [1:0] RESP_OKAY    = 2'b00;

    state_t                  state;
    state_t                  next_state;
    logic [31:0]             shadow [4];
    logic [1:0]              step;
    logic [1:0]              cur_idx;
    logic                    aw_done;
    logic                    w_done;
    logic [7:0]              tmo_cnt;
    logic                    tmo_hit;
    logic                    waiting;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    ar_hs;
    logic                    advance;
    logic                    fail;
    logic [1:0]              fail_code;
    logic                    rd_phase;
    logic [C_ADDR_WIDTH-1:0] reg_addr;

    // Writes go 1,2,3,0 so the enable in register 0 lands after the ratios; reads go 0..3.
    assign rd_phase = (state == S_RD_AR) || (state == S_RD_R);
    assign cur_idx  = rd_phase ? step : step + 2'd1;
    assign reg_addr = C_ADDR_WIDTH'({cur_idx, 2'b00});

    assign m_axi_awvalid = (state == S_WR_AW_W) && !aw_done;
    assign m_axi_wvalid  = (state == S_WR_AW_W) && !w_done;
    assign m_axi_bready  = (state == S_WR_B);
    assign m_axi_arvalid = (state == S_RD_AR);
    assign m_axi_rready  = (state == S_RD_R);

    assign m_axi_awaddr = m_axi_awvalid ? reg_addr : '0;
    assign m_axi_wdata  = m_axi_wvalid ? shadow[cur_idx] : 32'd0;
    assign m_axi_araddr = m_axi_arvalid ? reg_addr : '0;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wstrb  = 4'hF;

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;
    assign ar_hs = m_axi_arvalid && m_axi_arready;

    assign waiting   = (state == S_WR_AW_W) || (state == S_WR_B) || rd_phase;
    assign tmo_hit   = (tmo_cnt == 8'(C_TIMEOUT - 1));
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign fsm_state = state;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        advance    = 1'b0;
        fail       = 1'b0;
        fail_code  = 2'b00;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_WR_AW_W;
            end
            S_WR_AW_W: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    next_state = S_WR_B;
                end else if (tmo_hit) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            S_WR_B: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != RESP_OKAY) begin
                        fail      = 1'b1;
                        fail_code = ERR_RESP;
                    end else begin
                        advance    = 1'b1;
                        next_state = (step == 2'd3) ? S_RD_AR : S_WR_AW_W;
                    end
                end else if (tmo_hit) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            S_RD_AR: begin
                if (ar_hs) begin
                    next_state = S_RD_R;
                end else if (tmo_hit) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            S_RD_R: begin
                if (m_axi_rvalid) begin
                    if (m_axi_rresp != RESP_OKAY) begin
                        fail      = 1'b1;
                        fail_code = ERR_RESP;
                    end else if (m_axi_rdata != shadow[cur_idx]) begin
                        fail      = 1'b1;
                        fail_code = ERR_MISMATCH;
                    end else begin
                        advance    = 1'b1;
                        next_state = (step == 2'd3) ? S_DONE : S_RD_AR;
                    end
                end else if (tmo_hit) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            S_DONE:  next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (fail) next_state = S_ERR;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            step      <= 2'd0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            tmo_cnt   <= 8'd0;
            error     <= 1'b0;
            err_code  <= 2'b00;
            err_index <= 2'b00;
            for (int i = 0; i < 4; i++) shadow[i] <= 32'd0;
        end else begin
            if (state == S_WR_AW_W) begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end

            // Timeout window restarts on every state change.
            if (next_state != state) begin
                tmo_cnt <= 8'd0;
            end else if (waiting) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end

            if (state == S_IDLE && start) begin
                shadow[0] <= cfg_ctrl;
                shadow[1] <= cfg_div;
                shadow[2] <= cfg_high;
                shadow[3] <= cfg_phase;
                step      <= 2'd0;
                error     <= 1'b0;
                err_code  <= 2'b00;
                err_index <= 2'b00;
            end

            if (advance) step <= step + 2'd1;

            if (fail) begin
                error     <= 1'b1;
                err_code  <= fail_code;
                err_index <= cur_idx;
            end
        end
    end

endmodule

// File: tb/tb_clkdiv_cfg_sequencer.sv
// Directed bench for clkdiv_cfg_sequencer: an AXI4-Lite register slave with
// programmable stalls and fault injection, plus a linear sequence of checked scenarios.
module tb_clkdiv_cfg_sequencer;

    logic        clk;
    logic        areset;
    logic        start;
    logic [31:0] cfg_ctrl, cfg_div, cfg_high, cfg_phase;
    logic        busy, done, error;
    logic [1:0]  err_code, err_index;
    logic [2:0]  fsm_state;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    clkdiv_cfg_sequencer #(.C_ADDR_WIDTH(4), .C_TIMEOUT(255)) dut (
        .ACLK(clk), .ARESET(areset), .start(start),
        .cfg_ctrl(cfg_ctrl), .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
        .busy(busy), .done(done), .error(error), .err_code(err_code), .err_index(err_index),
        .fsm_state(fsm_state),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- slave model ----------------
    int          aw_wait, w_wait, bad_b_addr, bad_r_addr;
    logic [31:0] bad_r_data;
    int          aw_cnt, w_cnt, aw_n, w_n, wr_n, rd_n;
    logic        got_aw, got_w, aw_now, w_now;
    logic [3:0]  cur_aw, a_now;
    logic [31:0] cur_w, d_now;
    logic [31:0] mem [4];
    logic [35:0] wr_log [32];
    logic [3:0]  rd_log [32];

    assign awready = (aw_cnt >= aw_wait);
    assign wready  = (w_cnt >= w_wait);
    assign arready = 1'b1;

    always_comb begin
        aw_now = got_aw || (awvalid && awready);
        a_now  = got_aw ? cur_aw : awaddr;
        w_now  = got_w || (wvalid && wready);
        d_now  = got_w ? cur_w : wdata;
    end

    always @(posedge clk or posedge areset) begin
        if (areset) begin
            aw_cnt <= 0; w_cnt <= 0; aw_n <= 0; w_n <= 0; wr_n <= 0; rd_n <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; cur_aw <= 4'd0; cur_w <= 32'd0;
            bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= 32'd0;
            for (int i = 0; i < 4; i++) mem[i] <= 32'd0;
        end else begin
            if (awvalid && awready) begin
                got_aw <= 1'b1; cur_aw <= awaddr; aw_cnt <= 0; aw_n <= aw_n + 1;
            end else if (awvalid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (wvalid && wready) begin
                got_w <= 1'b1; cur_w <= wdata; w_cnt <= 0; w_n <= w_n + 1;
            end else if (wvalid) begin
                w_cnt <= w_cnt + 1;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (aw_now && w_now) begin
                got_aw <= 1'b0;
                got_w  <= 1'b0;
                bvalid <= 1'b1;
                bresp  <= (int'(a_now) == bad_b_addr) ? 2'b10 : 2'b00;
                mem[a_now[3:2]] <= d_now;
                if (wr_n < 32) wr_log[wr_n] <= {a_now, d_now};
                wr_n <= wr_n + 1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rresp  <= 2'b00;
                rdata  <= (int'(araddr) == bad_r_addr) ? bad_r_data : mem[araddr[3:2]];
                if (rd_n < 32) rd_log[rd_n] <= araddr;
                rd_n <= rd_n + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad   = 0;
    logic [35:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        areset = 1'b1;
        repeat (2) @(negedge clk);
        areset = 1'b0;
    endtask

    task automatic set_cfg(input logic [31:0] c0, c1, c2, c3);
        cfg_ctrl = c0; cfg_div = c1; cfg_high = c2; cfg_phase = c3;
    endtask

    // Returns at the falling edge right after the edge that samples start.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // cyc counts rising edges after the start-sampling edge; 0 means the bound expired.
    task automatic wait_end(input int bound, output int cyc, output logic sd, output logic se);
        cyc = 0; sd = 1'b0; se = 1'b0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (done || error) begin
                cyc = i; sd = done; se = error;
                break;
            end
        end
    endtask

    task automatic check_writes(input string tag, input int base);
        logic [35:0] e;
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            check($sformatf("%s_wr%0d", tag, i), wr_log[base + i], e);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired before the sequence finished");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    int   cyc, wb, rb, awb, wnb;
    logic sd, se;

    initial begin
        areset = 1'b1; start = 1'b0;
        aw_wait = 0; w_wait = 0; bad_b_addr = -1; bad_r_addr = -1; bad_r_data = 32'd0;
        set_cfg(32'd0, 32'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);

        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", {error, err_code, err_index}, 5'd0);
        check("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'd0);
        check("rst_prot_strb", {awprot, arprot, wstrb}, 10'h00F);
        check("rst_state", fsm_state, 3'd0);
        areset = 1'b0;

        // T1: zero-wait slave, 16 cycles start-to-done
        wb = wr_n; rb = rd_n;
        set_cfg(32'h1, 32'h10, 32'h8, 32'h2);
        pulse_start();
        check("t1_busy", busy, 1'b1);
        wait_end(64, cyc, sd, se);
        check("t1_done", sd, 1'b1);
        check("t1_err", se, 1'b0);
        check("t1_lat", cyc, 16);
        exp_q.push_back({4'h4, 32'h10});
        exp_q.push_back({4'h8, 32'h8});
        exp_q.push_back({4'hC, 32'h2});
        exp_q.push_back({4'h0, 32'h1});
        check_writes("t1", wb);
        check("t1_nwr", wr_n - wb, 4);
        check("t1_nrd", rd_n - rb, 4);
        for (int i = 0; i < 4; i++) check($sformatf("t1_rd%0d", i), rd_log[rb + i], 4 * i);
        @(negedge clk);
        check("t1_pulse_end", {done, busy}, 2'b00);

        // T2: wready immediate, awready 3 cycles later -> 5 cycles per write, 28 total
        aw_wait = 3;
        wb = wr_n; awb = aw_n; wnb = w_n;
        set_cfg(32'h1, 32'h20, 32'h10, 32'h4);
        pulse_start();
        wait_end(128, cyc, sd, se);
        check("t2_done", {sd, se}, 2'b10);
        check("t2_lat", cyc, 28);
        check("t2_aw_beats", aw_n - awb, 4);
        check("t2_w_beats", w_n - wnb, 4);
        exp_q.push_back({4'h4, 32'h20});
        exp_q.push_back({4'h8, 32'h10});
        exp_q.push_back({4'hC, 32'h4});
        exp_q.push_back({4'h0, 32'h1});
        check_writes("t2", wb);

        // T3: offset 0x4 reads back 0x11 -> mismatch at read 1 (edge 12)
        aw_wait = 0; bad_r_addr = 4; bad_r_data = 32'h11;
        rb = rd_n;
        set_cfg(32'h1, 32'h10, 32'h8, 32'h2);
        pulse_start();
        wait_end(64, cyc, sd, se);
        check("t3_flags", {sd, se}, 2'b01);
        check("t3_lat", cyc, 12);
        check("t3_code", err_code, 2'b10);
        check("t3_index", err_index, 2'd1);
        repeat (3) @(negedge clk);
        check("t3_sticky", {error, busy, done}, 3'b100);
        check("t3_nrd", rd_n - rb, 2);

        // T4: SLVERR on offset 0xC -> err at edge 6, no reads
        bad_r_addr = -1; bad_b_addr = 12;
        wb = wr_n; rb = rd_n;
        pulse_start();
        check("t4_err_cleared", error, 1'b0);
        wait_end(64, cyc, sd, se);
        check("t4_flags", {sd, se}, 2'b01);
        check("t4_lat", cyc, 6);
        check("t4_code", err_code, 2'b01);
        check("t4_index", err_index, 2'd3);
        check("t4_nwr", wr_n - wb, 3);
        check("t4_nrd", rd_n - rb, 0);

        // T5: awready stuck low; second start 4 edges in is ignored; abort after 255 waiting cycles
        bad_b_addr = -1; aw_wait = 1000000;
        awb = aw_n;
        set_cfg(32'h1, 32'h10, 32'h8, 32'h2);
        pulse_start();
        repeat (3) @(negedge clk);
        set_cfg(32'h0, 32'h55, 32'h66, 32'h77);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end(400, cyc, sd, se);
        // error lands on edge 255 after the first start; 4 edges were already consumed above
        check("t5_lat", cyc, 251);
        check("t5_flags", {sd, se}, 2'b01);
        check("t5_code", err_code, 2'b11);
        check("t5_index", err_index, 2'd1);
        check("t5_awvalid", awvalid, 1'b0);
        check("t5_aw_beats", aw_n - awb, 0);

        // T6: ARESET during RD_R, then a clean full run
        aw_wait = 0;
        do_reset();
        set_cfg(32'h1, 32'h10, 32'h8, 32'h2);
        pulse_start();
        for (int i = 0; i < 40 && fsm_state != 3'd4; i++) @(negedge clk);
        check("t6_in_rd_r", fsm_state, 3'd4);
        areset = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rst_out", {busy, done, error, err_code, err_index}, 7'd0);
        check("t6_rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'd0);
        @(negedge clk);
        areset = 1'b0;
        wb = wr_n; rb = rd_n;
        pulse_start();
        wait_end(64, cyc, sd, se);
        check("t6_done", {sd, se}, 2'b10);
        check("t6_lat", cyc, 16);
        check("t6_nrd", rd_n - rb, 4);
        exp_q.push_back({4'h4, 32'h10});
        exp_q.push_back({4'h8, 32'h8});
        exp_q.push_back({4'hC, 32'h2});
        exp_q.push_back({4'h0, 32'h1});
        check_writes("t6", wb);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
